// File: rtl/disp_hex_mux_n.sv
// -----------------------------------------------------------------------------
// disp_hex_mux_n
// Time-multiplexed hexadecimal seven-segment driver for N_DIG common-anode
// digits, with per-digit blanking, PWM brightness inside each digit slot and
// frame-synchronous (tear-free) update of the displayed values.
//
// Optional feature macro: DISP_LZB_EN (leading-zero blanking on the active
// registers). The default build leaves zeros visible.
//
// Parameters:
//   N_DIG   : number of digits (2..8)
//   DWELL_W : digit slot length is 2^DWELL_W clk cycles
//   BR_W    : brightness code width (BR_W <= DWELL_W)
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   hex_in   : hex nibbles, digit k = hex_in[4k+3:4k], digit 0 rightmost
//   dp_in    : decimal points per digit, active-low
//   blank_in : 1 = digit forced dark
//   upd      : single-cycle capture request for hex_in/dp_in/blank_in
//   bright   : brightness code (all ones = full on, 0 = dark)
//   an       : anode enables, active-low, at most one low (registered)
//   sseg     : {dp,g,f,e,d,c,b,a}, active-low (registered)
//   frame    : one-cycle pulse with digit 0's first slot output (registered)
//   upd_pend : a captured update awaits the next frame boundary (registered)
// -----------------------------------------------------------------------------
module disp_hex_mux_n #(
  parameter int N_DIG   = 4,
  parameter int DWELL_W = 16,
  parameter int BR_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*N_DIG-1:0] hex_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank_in,
  input  logic               upd,
  input  logic [BR_W-1:0]    bright,
  output logic [N_DIG-1:0]   an,
  output logic [7:0]         sseg,
  output logic               frame,
  output logic               upd_pend
);

  localparam logic [2:0]         LAST_DIG = 3'(N_DIG - 1);
  localparam logic [DWELL_W-1:0] SLOT_MAX = {DWELL_W{1'b1}};
  localparam logic [BR_W-1:0]    BR_FULL  = {BR_W{1'b1}};

  // Standard active-low hex decode, bit 6..0 = g..a.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'h40;
      4'h1:    hex_decode = 7'h79;
      4'h2:    hex_decode = 7'h24;
      4'h3:    hex_decode = 7'h30;
      4'h4:    hex_decode = 7'h19;
      4'h5:    hex_decode = 7'h12;
      4'h6:    hex_decode = 7'h02;
      4'h7:    hex_decode = 7'h78;
      4'h8:    hex_decode = 7'h00;
      4'h9:    hex_decode = 7'h10;
      4'hA:    hex_decode = 7'h08;
      4'hB:    hex_decode = 7'h03;
      4'hC:    hex_decode = 7'h46;
      4'hD:    hex_decode = 7'h21;
      4'hE:    hex_decode = 7'h06;
      4'hF:    hex_decode = 7'h0E;
      default: hex_decode = 7'h7F;
    endcase
  endfunction

  logic [DWELL_W-1:0] slot_q, slot_d;
  logic [2:0]         dig_q, dig_d;
  logic [4*N_DIG-1:0] hex_pnd_q, hex_pnd_d, hex_act_q, hex_act_d;
  logic [N_DIG-1:0]   dp_pnd_q, dp_pnd_d, dp_act_q, dp_act_d;
  logic [N_DIG-1:0]   blk_pnd_q, blk_pnd_d, blk_act_q, blk_act_d;
  logic               pend_q, pend_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;
  logic               frame_q, frame_d;

  logic               boundary_s;
  logic [N_DIG-1:0]   lzb_s;
  logic [N_DIG-1:0]   dark_s;
  logic [N_DIG-1:0]   an_sel_s;
  logic [3:0]         cur_hex_s;
  logic               cur_dp_s;
  logic               cur_dark_s;
  logic [BR_W-1:0]    top_s;
  logic               lit_s;
  logic               show_s;
`ifdef DISP_LZB_EN
  logic               lzb_scan_s;
`endif

  // The frame boundary is the cycle in which dig wraps back to 0.
  assign boundary_s = (slot_q == SLOT_MAX) && (dig_q == LAST_DIG);

  // Slot counter and digit index next state.
  always_comb begin
    slot_d = slot_q + DWELL_W'(1);
    dig_d  = dig_q;
    if (slot_q == SLOT_MAX) begin
      if (dig_q == LAST_DIG) begin
        dig_d = 3'd0;
      end else begin
        dig_d = dig_q + 3'd1;
      end
    end else begin
      dig_d = dig_q;
    end
  end

  // Capture into pending registers and commit pending to active at the boundary.
  always_comb begin
    hex_pnd_d = hex_pnd_q;
    dp_pnd_d  = dp_pnd_q;
    blk_pnd_d = blk_pnd_q;
    hex_act_d = hex_act_q;
    dp_act_d  = dp_act_q;
    blk_act_d = blk_act_q;
    pend_d    = pend_q;
    // The active copy takes the pending data that existed before this cycle,
    // so a capture coinciding with the boundary waits for the next one.
    if (boundary_s && pend_q) begin
      hex_act_d = hex_pnd_q;
      dp_act_d  = dp_pnd_q;
      blk_act_d = blk_pnd_q;
    end else begin
      hex_act_d = hex_act_q;
      dp_act_d  = dp_act_q;
      blk_act_d = blk_act_q;
    end
    if (upd) begin
      hex_pnd_d = hex_in;
      dp_pnd_d  = dp_in;
      blk_pnd_d = blank_in;
      pend_d    = 1'b1;
    end else if (boundary_s) begin
      pend_d    = 1'b0;
    end else begin
      pend_d    = pend_q;
    end
  end

  // Leading-zero blanking mask, evaluated on the active registers.
  always_comb begin
    lzb_s = {N_DIG{1'b0}};
`ifdef DISP_LZB_EN
    lzb_scan_s = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      if (lzb_scan_s && (hex_act_q[4*k +: 4] == 4'h0) && dp_act_q[k]) begin
        lzb_s[k] = 1'b1;
      end else begin
        lzb_scan_s = 1'b0;
      end
    end
`endif
  end

  assign dark_s = blk_act_q | lzb_s;

  // Select the current digit's active data and form the output next state.
  always_comb begin
    an_sel_s   = {N_DIG{1'b1}};
    cur_hex_s  = 4'h0;
    cur_dp_s   = 1'b1;
    cur_dark_s = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      an_sel_s[k] = (dig_q != 3'(k));
      cur_hex_s   = cur_hex_s | (hex_act_q[4*k +: 4] & {4{~an_sel_s[k]}});
      cur_dp_s    = cur_dp_s & (dp_act_q[k] | an_sel_s[k]);
      cur_dark_s  = cur_dark_s | (dark_s[k] & ~an_sel_s[k]);
    end
    // PWM window: the top BR_W bits of the slot counter against the code.
    top_s   = slot_q[DWELL_W-1 -: BR_W];
    lit_s   = (bright == BR_FULL) || (top_s < bright);
    show_s  = lit_s && !cur_dark_s;
    if (show_s) begin
      an_d   = an_sel_s;
      sseg_d = {cur_dp_s, hex_decode(cur_hex_s)};
    end else begin
      an_d   = {N_DIG{1'b1}};
      sseg_d = 8'hFF;
    end
    frame_d = (slot_q == {DWELL_W{1'b0}}) && (dig_q == 3'd0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q    <= {DWELL_W{1'b0}};
      dig_q     <= 3'd0;
      hex_pnd_q <= {(4*N_DIG){1'b0}};
      dp_pnd_q  <= {N_DIG{1'b1}};
      blk_pnd_q <= {N_DIG{1'b0}};
      hex_act_q <= {(4*N_DIG){1'b0}};
      dp_act_q  <= {N_DIG{1'b1}};
      blk_act_q <= {N_DIG{1'b0}};
      pend_q    <= 1'b0;
      an_q      <= {N_DIG{1'b1}};
      sseg_q    <= 8'hFF;
      frame_q   <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      dig_q     <= dig_d;
      hex_pnd_q <= hex_pnd_d;
      dp_pnd_q  <= dp_pnd_d;
      blk_pnd_q <= blk_pnd_d;
      hex_act_q <= hex_act_d;
      dp_act_q  <= dp_act_d;
      blk_act_q <= blk_act_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
      frame_q   <= frame_d;
    end
  end

  assign an       = an_q;
  assign sseg     = sseg_q;
  assign frame    = frame_q;
  assign upd_pend = pend_q;

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// -----------------------------------------------------------------------------
// tb_disp_hex_mux_n
// Directed self-checking bench for disp_hex_mux_n with N_DIG=4, DWELL_W=4,
// BR_W=2 (16-cycle slots, 64-cycle frames). cyc counts rising edges since the
// last reset release; the sample taken after edge cyc shows counter state
// cyc-1, so a frame's first output appears when cyc % 64 == 1.
// -----------------------------------------------------------------------------
module tb_disp_hex_mux_n;

  localparam int N_DIG   = 4;
  localparam int DWELL_W = 4;
  localparam int BR_W    = 2;
  localparam int FRAME   = 64;
  localparam logic [3:0] AN_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] hex_in = 16'h0000;
  logic [3:0]  dp_in = 4'b1111;
  logic [3:0]  blank_in = 4'b0000;
  logic        upd = 1'b0;
  logic [1:0]  bright = 2'd3;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame;
  logic        upd_pend;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  disp_hex_mux_n #(
    .N_DIG  (N_DIG),
    .DWELL_W(DWELL_W),
    .BR_W   (BR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .hex_in  (hex_in),
    .dp_in   (dp_in),
    .blank_in(blank_in),
    .upd     (upd),
    .bright  (bright),
    .an      (an),
    .sseg    (sseg),
    .frame   (frame),
    .upd_pend(upd_pend)
  );

  // One rising edge, then land on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic align(input int pos);
    while ((cyc % FRAME) != pos) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (an !== 4'b1111 || sseg !== 8'hFF || frame !== 1'b0 || upd_pend !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold got an=%b sseg=%h frame=%b pend=%b exp 1111/ff/0/0", an, sseg, frame, upd_pend);
    end
    reset = 1'b1;
    cyc = 0;
    tick();
    tests_run++;
    if (an !== 4'b1110 || sseg !== 8'hC0 || frame !== 1'b1 || upd_pend !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first got an=%b sseg=%h frame=%b pend=%b exp 1110/c0/1/0", an, sseg, frame, upd_pend);
    end
    // Mid-slot reset with an update pending and digit 0 lit.
    align(5);
    hex_in = 16'h1234;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tests_run++;
    if (upd_pend !== 1'b1 || an !== 4'b1110) begin
      tests_failed++;
      $display("FAIL reset_pre got pend=%b an=%b exp 1/1110", upd_pend, an);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (an !== 4'b1111 || sseg !== 8'hFF || frame !== 1'b0 || upd_pend !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async got an=%b sseg=%h frame=%b pend=%b exp 1111/ff/0/0", an, sseg, frame, upd_pend);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    tick();
    tests_run++;
    if (an !== 4'b1110 || sseg !== 8'hC0 || frame !== 1'b1 || upd_pend !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release got an=%b sseg=%h frame=%b pend=%b exp 1110/c0/1/0", an, sseg, frame, upd_pend);
    end
  endtask

  task automatic test_frame_update();
    logic [7:0] es [4] = '{8'hC0, 8'h80, 8'h88, 8'hF9};
    int d;
    bright = 2'd3;
    dp_in = 4'b1111;
    blank_in = 4'b0000;
    align(20);
    hex_in = 16'h1A80;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    hex_in = 16'hFFFF;
    while ((cyc % FRAME) != 0) begin
      tests_run++;
      if (upd_pend !== 1'b1 || sseg !== 8'hC0 && an !== 4'b1111) begin
        tests_failed++;
        $display("FAIL upd_wait cyc=%0d got pend=%b an=%b sseg=%h exp pend=1 old data", cyc, upd_pend, an, sseg);
      end
      tick();
    end
    tests_run++;
    if (upd_pend !== 1'b0) begin
      tests_failed++;
      $display("FAIL upd_commit got pend=%b exp 0", upd_pend);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      d = i / 16;
      tests_run++;
      if (an !== AN_SEL[d] || sseg !== es[d] || frame !== (i == 0)) begin
        tests_failed++;
        $display("FAIL frame_update i=%0d got an=%b sseg=%h frame=%b exp an=%b sseg=%h frame=%b",
                 i, an, sseg, frame, AN_SEL[d], es[d], (i == 0));
      end
    end
  endtask

  task automatic test_double_update();
    int d;
    align(10);
    hex_in = 16'h1111;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    align(40);
    hex_in = 16'h2222;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    hex_in = 16'h3333;
    tests_run++;
    if (upd_pend !== 1'b1) begin
      tests_failed++;
      $display("FAIL double_pend got %b exp 1", upd_pend);
    end
    align(0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        tick();
        d = i / 16;
        tests_run++;
        if (an !== AN_SEL[d] || sseg !== 8'hA4) begin
          tests_failed++;
          $display("FAIL double_update f=%0d i=%0d got an=%b sseg=%h exp an=%b sseg=a4", f, i, an, sseg, AN_SEL[d]);
        end
      end
    end
  endtask

  task automatic test_boundary_upd();
    int d;
    align(30);
    hex_in = 16'h4444;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    align(63);
    hex_in = 16'h5555;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tests_run++;
    if (upd_pend !== 1'b1) begin
      tests_failed++;
      $display("FAIL boundary_pend got %b exp 1", upd_pend);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      d = i / 16;
      tests_run++;
      if (an !== AN_SEL[d] || sseg !== 8'h99) begin
        tests_failed++;
        $display("FAIL boundary_old i=%0d got an=%b sseg=%h exp an=%b sseg=99", i, an, sseg, AN_SEL[d]);
      end
    end
    tests_run++;
    if (upd_pend !== 1'b0) begin
      tests_failed++;
      $display("FAIL boundary_clear got %b exp 0", upd_pend);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      d = i / 16;
      tests_run++;
      if (an !== AN_SEL[d] || sseg !== 8'h92) begin
        tests_failed++;
        $display("FAIL boundary_new i=%0d got an=%b sseg=%h exp an=%b sseg=92", i, an, sseg, AN_SEL[d]);
      end
    end
  endtask

  task automatic test_pwm();
    logic [1:0] codes [3] = '{2'd1, 2'd2, 2'd0};
    int         on_len [3] = '{4, 8, 0};
    logic [3:0] ea;
    logic [7:0] es;
    int d;
    align(0);
    for (int c = 0; c < 3; c++) begin
      bright = codes[c];
      for (int i = 0; i < FRAME; i++) begin
        tick();
        d = i / 16;
        ea = ((i % 16) < on_len[c]) ? AN_SEL[d] : 4'b1111;
        es = ((i % 16) < on_len[c]) ? 8'h92 : 8'hFF;
        tests_run++;
        if (an !== ea || sseg !== es) begin
          tests_failed++;
          $display("FAIL pwm bright=%0d i=%0d got an=%b sseg=%h exp an=%b sseg=%h", codes[c], i, an, sseg, ea, es);
        end
      end
    end
    bright = 2'd3;
  endtask

  task automatic test_blank();
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
    logic [7:0] es [4] = '{8'h40, 8'h80, 8'hFF, 8'hF9};
    int d;
    align(20);
    hex_in = 16'h1A80;
    dp_in = 4'b1110;
    blank_in = 4'b0100;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    blank_in = 4'b0000;
    align(0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      d = i / 16;
      tests_run++;
      if (an !== ea[d] || sseg !== es[d]) begin
        tests_failed++;
        $display("FAIL blank i=%0d got an=%b sseg=%h exp an=%b sseg=%h", i, an, sseg, ea[d], es[d]);
      end
    end
  endtask

  task automatic test_lzb();
    logic [15:0] vh [3] = '{16'h0050, 16'h0000, 16'h0005};
    logic [3:0]  vd [3] = '{4'b1111, 4'b1111, 4'b1011};
`ifdef DISP_LZB_EN
    logic [7:0]  es [3][4] = '{'{8'hC0, 8'h92, 8'hFF, 8'hFF},
                               '{8'hC0, 8'hFF, 8'hFF, 8'hFF},
                               '{8'h92, 8'hC0, 8'h40, 8'hFF}};
`else
    logic [7:0]  es [3][4] = '{'{8'hC0, 8'h92, 8'hC0, 8'hC0},
                               '{8'hC0, 8'hC0, 8'hC0, 8'hC0},
                               '{8'h92, 8'hC0, 8'h40, 8'hC0}};
`endif
    logic [3:0]  ea;
    int d;
    blank_in = 4'b0000;
    for (int v = 0; v < 3; v++) begin
      align(20);
      hex_in = vh[v];
      dp_in = vd[v];
      upd = 1'b1;
      tick();
      upd = 1'b0;
      align(0);
      for (int i = 0; i < FRAME; i++) begin
        tick();
        d = i / 16;
        ea = (es[v][d] == 8'hFF) ? 4'b1111 : AN_SEL[d];
        tests_run++;
        if (an !== ea || sseg !== es[v][d]) begin
          tests_failed++;
          $display("FAIL lzb v=%0d i=%0d got an=%b sseg=%h exp an=%b sseg=%h", v, i, an, sseg, ea, es[v][d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_update();
    test_double_update();
    test_boundary_upd();
    test_pwm();
    test_blank();
    test_lzb();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/disp_hex_mux_n.md
# disp_hex_mux_n

Parametrised time-multiplexed hexadecimal seven-segment driver for N_DIG common-anode digits. It adds three things to the fixed 4-digit driver:
- per-digit blanking;
- PWM brightness control within each digit slot;
- tear-free frame-synchronous update of displayed values.

It sits between the PWM/status logic and the board display pins, with one instance per display bank.

## Interface
Parameters:
- N_DIG, 4: number of digits, legal range 2..8.
- DWELL_W, 16: digit slot length is 2^DWELL_W clk cycles.
- BR_W, 4: brightness code width; must satisfy BR_W ≤ DWELL_W.

Ports (clock and reset first):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- hex_in  in  4*N_DIG  hex nibbles; digit k is hex_in[4k+3:4k], and digit 0 is rightmost.
- dp_in  in  N_DIG  decimal-point drive per digit, active-low (1 = point off).
- blank_in  in  N_DIG  1 = digit k forced dark.
- upd  in  1  single-cycle request to capture hex_in/dp_in/blank_in.
- bright  in  BR_W  brightness code.
- an  out  N_DIG  anode enables, active-low, at most one low at any time.
- sseg  out  8  bit 7 = dp, bits 6..0 = {g,f,e,d,c,b,a}, active-low.
- frame  out  1  one-cycle pulse when digit 0 slot begins.
- upd_pend  out  1  a captured update is awaiting the next frame boundary.

## Operation
- Free-running counter: slot counter slot_cnt (DWELL_W bits) plus digit index dig (3 bits). When slot_cnt wraps, dig advances, going from N_DIG-1 back to 0.
- Capture:
  - upd=1 latches the inputs into pending registers and sets upd_pend.
  - A second upd before the boundary overwrites the pending registers; only the last capture is used.
- Commit: at the cycle in which dig wraps to 0 (the frame boundary), pending registers copy into the active registers and upd_pend clears.
  - If upd coincides with the boundary, that capture goes to pending and commits at the next boundary. The previous pending data commits now.
- Display always uses the active registers and never the raw inputs.
- Decoder, standard hex, active-low. Examples: 0→0x40, 1→0x79, 8→0x00, A→0x08, F→0x0E.
- Brightness: let top = slot_cnt[DWELL_W-1 -: BR_W].
  - Digit is lit when bright = 2^BR_W-1, or when top < bright.
  - bright = 0 means the display is dark.
- A digit that is blanked, or outside its PWM on-window, drives an all ones and sseg = 0xFF.
- Lit digit: an has only bit dig low; sseg = {dp_active[dig], decode(hex_active[dig])}.

## Timing
- an, sseg, frame and upd_pend are all registered.
- an and sseg reflect the counter state with 1 cycle latency.
- frame is high in the same cycle as the registered output of digit 0's first slot cycle.
- Commit-to-display latency ≤ one full frame (N_DIG·2^DWELL_W cycles) plus 1.
- Reset (asynchronous assert, synchronous-release-safe, clears mid-slot immediately):
  - an = all ones, sseg = 0xFF, frame = 0, upd_pend = 0.
  - Counters = 0.
  - Active and pending registers: hex = 0, dp = all ones, blank = 0.
- A brightness change takes effect on the next clock with no frame alignment. bright is not captured by upd.

## Configuration
- DISP_LZB_EN defined: leading-zero blanking is enabled.
  - Scanning from digit N_DIG-1 downward, each digit whose active nibble is 0 and whose active dp is off is blanked.
  - Scanning stops at the first non-zero nibble or lit dp.
  - Digit 0 is never blanked by this rule.
  - Blanking is evaluated on active registers, so it is frame-synchronous.
- DISP_LZB_EN undefined: zeros display normally; only blank_in darkens digits.

## Test plan
All scenarios use N_DIG=4, DWELL_W=4, BR_W=2.
- Reset: assert reset mid-slot → an=4'b1111, sseg=0xFF, and upd_pend=0 within the same cycle.
- Frame update: upd with hex_in=0x1A80, bright=3 → upd_pend=1 until frame. The following frame then shows in sequence an=1110/sseg=0xC0, 1101/0x80, 1011/0x88, 0111/0xF9, each lasting 16 cycles.
- Double update: upd with 0x1111, then upd with 0x2222 before the boundary → only 0x2222 appears, and 0x1111 is never displayed.
- PWM: bright=1 → each digit lit for 4 of 16 slot cycles. bright=0 → an stays 1111 for the whole frame.
- Blanking: blank_in=4'b0100, dp_in=4'b1110 → digit 2 stays dark, and digit 0 shows sseg[7]=0.
- Leading zeros: hex_in=0x0050 with DISP_LZB_EN → digits 3 and 2 dark, digits 1 and 0 show 0x92 and 0xC0. Without the macro, digits 3 and 2 show 0xC0.
